// File: rtl/count_run_arbiter.sv
// count_run_arbiter
//
// Shares one WIDTH-bit up-counter between two requesters. A winner is picked
// round-robin in IDLE. Its run length is latched, and the counter steps from 0
// up to that length. A one-cycle done pulse marks a run that completes
// normally. An abort ends the run early with no done pulse.
//
// Handshake: req0/req1 are level requests. They are sampled only in IDLE.
// gnt<n> stays high for tlen+1 cycles while the counter runs, then done<n>
// pulses for one cycle. A request that is still high after that is treated as
// a new request.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   req0, req1   level requests
//   len0, len1   terminal counts, sampled when the grant is given
//   abort        ends a RUN immediately, without a done pulse
//   gnt0, gnt1   ownership of the counter (one-hot or zero)
//   busy         high whenever the FSM is not IDLE
//   cnt          shared counter value
//   done0, done1 one-cycle pulse on normal completion of a run
// All outputs are registered.
module count_run_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             abort,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] cnt,
    output logic             done0,
    output logic             done1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] tlen_q, tlen_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             winner;

    // On a tie, the requester that was not served last wins.
    // With a single request, that request wins.
    assign winner = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tlen_d  = tlen_q;
        cnt_d   = cnt_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        busy_d  = busy_q;
        done0_d = 1'b0;
        done1_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 || req1) begin
                    owner_d = winner;
                    tlen_d  = winner ? len1 : len0;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else if (cnt_q == tlen_q) begin
                    // The terminal count ends the run, so the counter never wraps.
                    // busy stays high through the single DONE cycle.
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    cnt_d   = '0;
                    last_d  = owner_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // abort is ignored in this state.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;  // lets requester 0 win the first tie
            tlen_q  <= '0;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tlen_q  <= tlen_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign busy  = busy_q;
    assign cnt   = cnt_q;
    assign done0 = done0_q;
    assign done1 = done1_q;

endmodule

// File: doc/count_run_arbiter.md
# count_run_arbiter

Controller that shares one WIDTH-bit up-counter between two requesters. Each requester asks for a counting run of a given length. The block arbitrates round-robin, sequences the counter from 0 up to the latched length, and pulses a per-requester done. It sits between client FSMs and the 3-bit counter datapath, which it owns and exposes on `cnt`.

## Interface
- WIDTH, 3, counter and length width; max run length 2^WIDTH-1
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-low
- req0  input  1  level request from requester 0
- req1  input  1  level request from requester 1
- len0  input  WIDTH  terminal count for requester 0, sampled at grant
- len1  input  WIDTH  terminal count for requester 1, sampled at grant
- abort  input  1  terminate current run without done
- gnt0  output  1  requester 0 owns the counter
- gnt1  output  1  requester 1 owns the counter
- busy  output  1  high whenever state is not IDLE
- cnt  output  WIDTH  shared counter value
- done0  output  1  one-cycle pulse, run 0 completed normally
- done1  output  1  one-cycle pulse, run 1 completed normally

## Operation
- Internal state: 2-bit FSM {IDLE, RUN, DONE}, `owner` (1 bit), `last` (1 bit, last served), `tlen` (WIDTH, latched length).
- All outputs are registered. Reset values: state=IDLE, cnt=0, gnt0=gnt1=0, done0=done1=0, busy=0, last=1 (so requester 0 wins the first tie), tlen=0, owner=0.
- IDLE:
  - No request: hold; cnt=0.
  - Exactly one request: grant it.
  - Both requests: grant the requester != `last`.
  - On grant: owner<=winner, tlen<=len_winner, cnt<=0, gnt_winner<=1, busy<=1, go RUN.
- RUN:
  - If abort: go IDLE; gnt<=0, busy<=0, cnt<=0, last<=owner; no done pulse.
  - Else if cnt==tlen: go DONE; done_owner<=1, gnt<=0, cnt<=0, last<=owner.
  - Else cnt<=cnt+1.
- DONE: done<=0, busy<=0, go IDLE. abort is ignored in this state.
- Arithmetic: cnt never wraps within a run; the maximum tlen of 2^WIDTH-1 ends at cnt=all-ones. len=0 gives a single RUN cycle with cnt=0.
- Changes to len after grant have no effect. Deasserting req during RUN has no effect; the run completes.
- A req still high in IDLE after its own DONE is a new request. Round-robin gives the other requester priority if it is also requesting.
- gnt0 and gnt1 are never high together. done0 and done1 are never high together.

## Timing
- Edge E0 samples req in IDLE. gnt and busy are high after E0, with cnt=0.
- After edge E0+k (k≤tlen), cnt=k.
- The edge following cnt==tlen drops gnt and raises done for one cycle.
- Run occupies tlen+1 cycles with gnt high, then 1 DONE cycle, then at least 1 IDLE cycle.
- Back-to-back grant spacing is therefore tlen+3 cycles.
- abort sampled high in RUN: gnt, busy and cnt clear at that same edge. The next grant is arbitrated one edge later.
- Asynchronous reset mid-run: every output returns to its reset value immediately, with no done pulse. The first post-reset tie goes to requester 0.

## Test plan
- Reset, then req0=1, len0=3: cnt 0,1,2,3 over 4 cycles with gnt0=1; done0 pulses 1 cycle at the next edge while gnt0=0 and cnt=0. busy drops one cycle later.
- req0=req1=1 held, len0=2, len1=1 from reset: grant order 0,1,0,1. gnt never overlaps, and each done pulse matches its owner.
- req1=1, len1=0: gnt1 high exactly 1 cycle with cnt=0, then done1 pulse.
- len0=7 (WIDTH=3): cnt reaches 7, done0 fires, cnt returns to 0 with no wrap to 0 during gnt0.
- Run len0=5, abort at cnt=2: gnt0, busy and cnt clear at that edge with no done0. Pending req1 is granted at the following IDLE edge.
- Async reset asserted at cnt=4 of a run: outputs clear without waiting for clk. After release, with req0=req1=1, requester 0 is granted first.
